// File: rtl/adsr_pkg.sv
// -----------------------------------------------------------------------------
// adsr_pkg
// Shared types and constants for the 32-bit ADSR envelope generator.
//   adsr_state_t : 3-bit state codes (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3,
//                  RELEASE=4; codes 5..7 are illegal)
//   ADSR_W       : envelope / rate width
//   ADSR_MAX     : full-scale envelope level
// -----------------------------------------------------------------------------
package adsr_pkg;

  localparam int ADSR_W = 32;
  localparam logic [ADSR_W-1:0] ADSR_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_t;

endpackage

// File: rtl/adsr_sat_step.sv
// -----------------------------------------------------------------------------
// adsr_sat_step
// Combinational saturating step toward a target level.
//   i_level    : current envelope level
//   i_rate     : step size (0 means jump straight to the target)
//   i_target   : level at which the ramp stops
//   i_dir_down : 0 = add (ramp up), 1 = subtract (ramp down)
//   o_level    : next level (clamped to i_target when reached)
//   o_reached  : the step hit, crossed or overflowed past the target
// -----------------------------------------------------------------------------
module adsr_sat_step
  import adsr_pkg::*;
(
  input  logic [ADSR_W-1:0] i_level,
  input  logic [ADSR_W-1:0] i_rate,
  input  logic [ADSR_W-1:0] i_target,
  input  logic              i_dir_down,
  output logic [ADSR_W-1:0] o_level,
  output logic              o_reached
);

  // One extra bit catches carry (add) and borrow (subtract).
  logic [ADSR_W:0] w_sum;
  logic [ADSR_W:0] w_diff;

  assign w_sum  = {1'b0, i_level} + {1'b0, i_rate};
  assign w_diff = {1'b0, i_level} - {1'b0, i_rate};

  always_comb begin
    o_reached = 1'b0;
    o_level   = i_level;
    if (i_dir_down) begin
      o_reached = w_diff[ADSR_W] || (w_diff[ADSR_W-1:0] <= i_target) || (i_rate == '0);
      o_level   = o_reached ? i_target : w_diff[ADSR_W-1:0];
    end else begin
      o_reached = w_sum[ADSR_W] || (w_sum[ADSR_W-1:0] >= i_target) || (i_rate == '0);
      o_level   = o_reached ? i_target : w_sum[ADSR_W-1:0];
    end
  end

endmodule

// File: rtl/adsr_32.sv
// -----------------------------------------------------------------------------
// adsr_32
// 32-bit linear ADSR envelope generator, one registered stage.
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset (sout=0, state=IDLE)
//   GATE  : note on (1) / note off (0)
//   A     : attack increment per clock (0 = instant)
//   D     : decay decrement per clock (0 = instant)
//   S     : sustain level
//   R     : release decrement per clock (0 = instant)
//   sout  : registered envelope level
//   state : registered state code, only when ADSR32_STATE_PORT_EN is defined
// Optional feature macro: ADSR32_STATE_PORT_EN
// -----------------------------------------------------------------------------
module adsr_32
  import adsr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              GATE,
  input  logic [ADSR_W-1:0] A,
  input  logic [ADSR_W-1:0] D,
  input  logic [ADSR_W-1:0] S,
  input  logic [ADSR_W-1:0] R,
  output logic [ADSR_W-1:0] sout
`ifdef ADSR32_STATE_PORT_EN
  ,
  output logic [2:0]        state
`endif
);

  adsr_state_t       r_state;
  adsr_state_t       w_state_next;
  logic [ADSR_W-1:0] r_sout;
  logic [ADSR_W-1:0] w_sout_next;

  // Shared step unit, steered by the current state.
  logic [ADSR_W-1:0] w_step_rate;
  logic [ADSR_W-1:0] w_step_target;
  logic              w_step_down;
  logic [ADSR_W-1:0] w_step_level;
  logic              w_step_reached;

  always_comb begin
    w_step_rate   = R;
    w_step_target = '0;
    w_step_down   = 1'b1;
    case (r_state)
      ST_ATTACK: begin
        w_step_rate   = A;
        w_step_target = ADSR_MAX;
        w_step_down   = 1'b0;
      end
      ST_DECAY: begin
        w_step_rate   = D;
        w_step_target = S;
      end
      default: begin
        w_step_rate   = R;
        w_step_target = '0;
      end
    endcase
  end

  adsr_sat_step u_step (
    .i_level    (r_sout),
    .i_rate     (w_step_rate),
    .i_target   (w_step_target),
    .i_dir_down (w_step_down),
    .o_level    (w_step_level),
    .o_reached  (w_step_reached)
  );

  // GATE-driven transitions take priority over rate-driven ones and hold the
  // level on the transition clock; the new phase steps from the next clock.
  always_comb begin
    w_state_next = r_state;
    w_sout_next  = r_sout;
    case (r_state)
      ST_IDLE: begin
        w_sout_next = '0;
        if (GATE) w_state_next = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (!GATE) begin
          w_state_next = ST_RELEASE;
        end else begin
          w_sout_next = w_step_level;
          if (w_step_reached) w_state_next = ST_DECAY;
        end
      end
      ST_DECAY: begin
        if (!GATE) begin
          w_state_next = ST_RELEASE;
        end else begin
          w_sout_next = w_step_level;
          if (w_step_reached) w_state_next = ST_SUSTAIN;
        end
      end
      ST_SUSTAIN: begin
        if (!GATE) begin
          w_state_next = ST_RELEASE;
        end else begin
          // Track S live so sustain-level edits apply immediately.
          w_sout_next = S;
        end
      end
      ST_RELEASE: begin
        if (GATE) begin
          // Retrigger: attack resumes from the current level.
          w_state_next = ST_ATTACK;
        end else begin
          w_sout_next = w_step_level;
          if (w_step_reached) w_state_next = ST_IDLE;
        end
      end
      default: begin
        // Illegal codes fall back to a silent IDLE.
        w_state_next = ST_IDLE;
        w_sout_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sout  <= '0;
    end else begin
      r_state <= w_state_next;
      r_sout  <= w_sout_next;
    end
  end

  assign sout = r_sout;

`ifdef ADSR32_STATE_PORT_EN
  assign state = r_state;
`endif

endmodule

// File: tb/tb_adsr_32.sv
// -----------------------------------------------------------------------------
// tb_adsr_32
// Self-checking bench for adsr_32: directed envelope scenarios followed by a
// randomized run, every cycle compared against a behavioural envelope model.
// The state port is checked only when ADSR32_STATE_PORT_EN is defined.
// -----------------------------------------------------------------------------
module tb_adsr_32;

  localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        gate;
  logic [31:0] a_rate, d_rate, s_lvl, r_rate;
  logic [31:0] sout;
`ifdef ADSR32_STATE_PORT_EN
  logic [2:0]  state;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase number (0 idle, 1 attack, 2 decay, 3 sustain, 4 release)
  // and level as a wide signed integer so overflow/underflow is visible.
  int     m_phase;
  longint m_level;

  always #5 clk = ~clk;

  adsr_32 dut (
    .clk  (clk),
    .rst  (rst),
    .GATE (gate),
    .A    (a_rate),
    .D    (d_rate),
    .S    (s_lvl),
    .R    (r_rate),
    .sout (sout)
`ifdef ADSR32_STATE_PORT_EN
    ,
    .state(state)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Envelope rules applied to the values present at this clock edge.
  task automatic model_edge();
    longint t;
    if (rst) begin
      m_phase = 0;
      m_level = 0;
    end else begin
      case (m_phase)
        0: begin
          m_level = 0;
          if (gate) m_phase = 1;
        end
        1: if (!gate) m_phase = 4;
           else begin
             t = m_level + longint'(a_rate);
             if (a_rate == 0 || t >= MAXV) begin m_level = MAXV; m_phase = 2; end
             else m_level = t;
           end
        2: if (!gate) m_phase = 4;
           else begin
             t = m_level - longint'(d_rate);
             if (d_rate == 0 || t <= longint'(s_lvl)) begin m_level = longint'(s_lvl); m_phase = 3; end
             else m_level = t;
           end
        3: if (!gate) m_phase = 4;
           else m_level = longint'(s_lvl);
        default: if (gate) m_phase = 1;
           else begin
             t = m_level - longint'(r_rate);
             if (r_rate == 0 || t <= 0) begin m_level = 0; m_phase = 0; end
             else m_level = t;
           end
      endcase
    end
  endtask

  // One clock: advance the model at the edge, then compare 1 time unit later.
  task automatic step();
    logic [31:0] exp_lvl;
    logic [31:0] exp_st;
    @(posedge clk);
    model_edge();
    #1;
    exp_lvl = m_level[31:0];
    check_eq("model_sout", sout, exp_lvl);
`ifdef ADSR32_STATE_PORT_EN
    exp_st = m_phase;
    check_eq("model_state", {29'd0, state}, exp_st);
`else
    exp_st = 32'd0;
`endif
  endtask

  task automatic step_expect(input string tag, input logic [31:0] exp_lvl, input int exp_phase);
    logic [31:0] ph;
    step();
    check_eq(tag, sout, exp_lvl);
    ph = exp_phase;
`ifdef ADSR32_STATE_PORT_EN
    check_eq({tag, "_state"}, {29'd0, state}, ph);
`else
    if (ph > 32'd4) $display("note: odd phase %0d", ph);
`endif
  endtask

  function automatic logic [31:0] rnd_rate();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'd0;
    if (sel == 1) return $urandom_range(1, 4);
    return $urandom >> $urandom_range(0, 6);
  endfunction

  initial begin
    rst = 1'b1; gate = 1'b0;
    a_rate = 32'd0; d_rate = 32'd2; s_lvl = 32'd3; r_rate = 32'd4;
    m_phase = 0; m_level = 0;

    // Reset then idle
    step_expect("reset0", 32'h0, 0);
    step_expect("reset1", 32'h0, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step_expect("idle", 32'h0, 0);

    // Attack saturation
    a_rate = 32'h4000_0000; d_rate = 32'h8000_0000;
    s_lvl  = 32'h1000_0000; r_rate = 32'h0800_0000;
    gate = 1'b1;
    step_expect("atk_enter", 32'h0, 1);
    step_expect("atk1", 32'h4000_0000, 1);
    step_expect("atk2", 32'h8000_0000, 1);
    step_expect("atk3", 32'hC000_0000, 1);
    step_expect("atk_sat", 32'hFFFF_FFFF, 2);
    // Decay clamp
    step_expect("dec1", 32'h7FFF_FFFF, 2);
    step_expect("dec_clamp", 32'h1000_0000, 3);
    step_expect("sus_hold", 32'h1000_0000, 3);
    step_expect("sus_hold2", 32'h1000_0000, 3);
    // Release
    gate = 1'b0;
    step_expect("rel_enter", 32'h1000_0000, 4);
    step_expect("rel1", 32'h0800_0000, 4);
    step_expect("rel_end", 32'h0, 0);
    step_expect("idle_after", 32'h0, 0);

    // Zero rates
    a_rate = 32'd0; d_rate = 32'd2; s_lvl = 32'd3; r_rate = 32'd4;
    gate = 1'b1;
    step_expect("z_enter", 32'h0, 1);
    step_expect("z_atk", 32'hFFFF_FFFF, 2);
    step_expect("z_dec1", 32'hFFFF_FFFD, 2);
    step_expect("z_dec2", 32'hFFFF_FFFB, 2);
    gate = 1'b0;
    step_expect("z_rel_enter", 32'hFFFF_FFFB, 4);
    step_expect("z_rel1", 32'hFFFF_FFF7, 4);
    step_expect("z_rel2", 32'hFFFF_FFF3, 4);

    // Retrigger from 0x5000_0000
    rst = 1'b1;
    step_expect("rt_reset", 32'h0, 0);
    rst = 1'b0;
    a_rate = 32'h5000_0000; r_rate = 32'h0100_0000;
    gate = 1'b1;
    step_expect("rt_enter", 32'h0, 1);
    step_expect("rt_atk", 32'h5000_0000, 1);
    gate = 1'b0;
    step_expect("rt_rel", 32'h5000_0000, 4);
    gate = 1'b1; a_rate = 32'h1000_0000;
    step_expect("rt_retrig", 32'h5000_0000, 1);
    step_expect("rt_step", 32'h6000_0000, 1);

    // Randomized run against the model
    begin
      int hold;
      hold = 0;
      rst = 1'b0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        if (hold == 0) begin
          gate = ~gate;
          hold = $urandom_range(1, 60);
        end
        hold--;
        if ($urandom_range(0, 29) == 0) begin
          case ($urandom_range(0, 3))
            0: a_rate = rnd_rate();
            1: d_rate = rnd_rate();
            2: s_lvl  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            default: r_rate = rnd_rate();
          endcase
        end
        rst = ($urandom_range(0, 199) == 0);
        step();
      end
      rst = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
